// File: rtl/ddr_tx_serializer.sv
// ddr_tx_serializer: HDR-DDR transmit serializer, MSB-first, one bit per SCL edge strobe.
// Adds word parity to data frames and accumulates CRC-5 over data payload bits.
module ddr_tx_serializer #(
    parameter int         DATA_W   = 16,
    parameter int         LEN_W    = 5,
    parameter logic [4:0] CRC_INIT = 5'h1F,
    parameter logic [4:0] CRC_POLY = 5'h05
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_ddrccc_tx_en,
    input  logic              i_sclgen_scl_pos_edge,
    input  logic              i_sclgen_scl_neg_edge,
    input  logic              i_ddrccc_tx_start,
    input  logic [2:0]        i_ddrccc_tx_mode,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic [LEN_W-1:0]  i_tx_len,
    input  logic [1:0]        i_preamble,
    input  logic              i_crc_clear,
    output logic              o_sdahnd_serial_data,
    output logic              o_ddrccc_mode_done,
    output logic              o_busy,
    output logic              o_mode_err,
    output logic [4:0]        o_crc_value,
    output logic [1:0]        o_parity
);
    localparam int SW = (DATA_W + 2 > 9) ? DATA_W + 2 : 9;
    localparam int CW = ($clog2(SW + 1) > LEN_W) ? $clog2(SW + 1) : LEN_W;
    localparam logic [2:0] M_PRE = 3'd1, M_DATA = 3'd2, M_CRC = 3'd3, M_ZERO = 3'd4, M_RAW = 3'd5;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t          state;
    logic [SW-1:0]   shreg, load_val;
    logic [CW-1:0]   cnt, load_cnt;
    logic [2:0]      mode;
    logic [4:0]      crc, crc_next;
    logic [LEN_W-1:0] raw_len;
    logic            p1, p0, scl_edge, accept, reserved, shifting, crc_frame;

    always_comb begin
        p1 = 1'b0;
        p0 = 1'b1;
        for (int i = 0; i < DATA_W; i++)
            if (i % 2 == 1) p1 = p1 ^ i_tx_data[i];
            else p0 = p0 ^ i_tx_data[i];
    end

    assign scl_edge  = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
    assign reserved  = (i_ddrccc_tx_mode == 3'd0) || (i_ddrccc_tx_mode > M_RAW);
    assign accept    = i_ddrccc_tx_en && i_ddrccc_tx_start && (state == IDLE || o_ddrccc_mode_done);
    assign shifting  = (state == LOAD || state == SHIFT) && scl_edge;
    assign crc_frame = (state == LOAD || state == SHIFT) && mode == M_CRC;
    assign raw_len   = (i_tx_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : i_tx_len;
    assign crc_next  = {crc[3:0], 1'b0} ^ ((crc[4] ^ shreg[SW-1]) ? CRC_POLY : 5'h00);
    assign o_crc_value = crc;

    // Frames are left-aligned so the first bit always sits in the MSB.
    assign load_val =
        (i_ddrccc_tx_mode == M_PRE)  ? SW'(i_preamble) << (SW - 2) :
        (i_ddrccc_tx_mode == M_DATA) ? SW'({i_tx_data, p1, p0}) << (SW - DATA_W - 2) :
        (i_ddrccc_tx_mode == M_CRC)  ? SW'({4'b1100, crc}) << (SW - 9) :
        (i_ddrccc_tx_mode == M_RAW)  ? SW'(i_tx_data) << (CW'(SW) - CW'(raw_len)) :
                                       '0;
    assign load_cnt =
        (i_ddrccc_tx_mode == M_PRE)  ? CW'(2) :
        (i_ddrccc_tx_mode == M_DATA) ? CW'(DATA_W + 2) :
        (i_ddrccc_tx_mode == M_CRC)  ? CW'(9) :
        (i_ddrccc_tx_mode == M_ZERO) ? CW'(i_tx_len) :
                                       CW'(raw_len);

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst) begin
            state                <= IDLE;
            shreg                <= '0;
            cnt                  <= '0;
            mode                 <= 3'd0;
            o_sdahnd_serial_data <= 1'b1;
            o_ddrccc_mode_done   <= 1'b0;
            o_busy               <= 1'b0;
            o_mode_err           <= 1'b0;
            o_parity             <= 2'b00;
        end else if (!i_ddrccc_tx_en) begin
            state                <= IDLE;
            o_sdahnd_serial_data <= 1'b1;
            o_ddrccc_mode_done   <= 1'b0;
            o_busy               <= 1'b0;
            o_mode_err           <= 1'b0;
        end else begin
            o_mode_err         <= accept && reserved;
            o_ddrccc_mode_done <= 1'b0;
            if (accept && reserved) begin
                state  <= IDLE;
                o_busy <= 1'b0;
            end else if (accept) begin
                shreg  <= load_val;
                cnt    <= load_cnt;
                mode   <= i_ddrccc_tx_mode;
                o_busy <= 1'b1;
                if (i_ddrccc_tx_mode == M_DATA) o_parity <= {p1, p0};
                if (load_cnt == '0) begin
                    state              <= DONE;
                    o_ddrccc_mode_done <= 1'b1;
                end else state <= LOAD;
            end else if (state == DONE) begin
                state  <= IDLE;
                o_busy <= 1'b0;
            end else if (shifting) begin
                o_sdahnd_serial_data <= shreg[SW-1];
                shreg                <= {shreg[SW-2:0], 1'b0};
                cnt                  <= cnt - 1'b1;
                state                <= SHIFT;
                if (cnt == CW'(1)) begin
                    state              <= DONE;
                    o_ddrccc_mode_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst) crc <= CRC_INIT;
        else if (i_crc_clear && !crc_frame) crc <= CRC_INIT;
        else if (i_ddrccc_tx_en && shifting && mode == M_DATA && cnt > CW'(2)) crc <= crc_next;
        else if (i_ddrccc_tx_en && shifting && mode == M_CRC && cnt == CW'(1)) crc <= CRC_INIT;
    end
endmodule

// File: tb/tb_ddr_tx_serializer.sv
// tb_ddr_tx_serializer: directed checks of ddr_tx_serializer with hand-computed bit streams.
module tb_ddr_tx_serializer;
    logic        clk, rst, en, pos, neg, start, crc_clear;
    logic [2:0]  mode;
    logic [15:0] data;
    logic [4:0]  len;
    logic [1:0]  pre;
    logic        ser, done, busy, err;
    logic [4:0]  crc;
    logic [1:0]  parity;
    int          n_chk, n_pass, phase;
    logic [1:0]  sp;
    bit          tog;

    ddr_tx_serializer dut (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_ddrccc_tx_en(en),
        .i_sclgen_scl_pos_edge(pos), .i_sclgen_scl_neg_edge(neg),
        .i_ddrccc_tx_start(start), .i_ddrccc_tx_mode(mode), .i_tx_data(data),
        .i_tx_len(len), .i_preamble(pre), .i_crc_clear(crc_clear),
        .o_sdahnd_serial_data(ser), .o_ddrccc_mode_done(done), .o_busy(busy),
        .o_mode_err(err), .o_crc_value(crc), .o_parity(parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // sp: 0 no strobes, 1 every cycle, 2 every other cycle, 3 pos+neg together every cycle
    task automatic step(output bit strobed);
        phase++;
        strobed = (sp == 2'd1) || (sp == 2'd3) || (sp == 2'd2 && phase % 2 == 0);
        pos = strobed && (sp == 2'd3 || tog);
        neg = strobed && (sp == 2'd3 || !tog);
        if (strobed) tog = !tog;
        @(posedge clk);
        #1;
        pos = 0; neg = 0; start = 0; crc_clear = 0;
    endtask

    task automatic tick();
        bit s;
        step(s);
    endtask

    task automatic start_frame(input logic [2:0] m, input logic [15:0] d, input logic [4:0] l, input logic [1:0] p);
        mode = m; data = d; len = l; pre = p; start = 1;
        tick();
    endtask

    task automatic frame_bits(input string tag, input logic [31:0] bits, input int n, input int stop);
        int i = 0;
        int cyc = 0;
        bit s;
        while (i < stop && cyc < 200) begin
            step(s);
            cyc++;
            if (s) begin
                check($sformatf("%s bit%0d", tag, i), ser, bits[n-1-i]);
                check($sformatf("%s done%0d", tag, i), done, i == n - 1);
                i++;
            end
        end
        if (i < stop) check({tag, " timeout"}, i, stop);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; phase = 0; tog = 1; sp = 0;
        rst = 0; en = 1; pos = 0; neg = 0; start = 0; crc_clear = 0;
        mode = 0; data = 0; len = 0; pre = 0;
        tick(); tick();
        check("rst ser", ser, 1);
        check("rst done", done, 0);
        check("rst busy", busy, 0);
        check("rst err", err, 0);
        check("rst parity", parity, 0);
        check("rst crc", crc, 5'h1F);
        rst = 1;
        tick();

        sp = 1;
        start_frame(3'b010, 16'h8000, 0, 0);
        check("d8000 busy", busy, 1);
        frame_bits("d8000", {14'b0, 16'h8000, 2'b11}, 18, 18);
        check("d8000 parity", parity, 2'b11);
        tick();
        check("d8000 idle busy", busy, 0);
        check("d8000 idle done", done, 0);

        start_frame(3'b010, 16'h0001, 0, 0);
        frame_bits("d0001", {14'b0, 16'h0001, 2'b00}, 18, 18);
        check("d0001 parity", parity, 2'b00);
        tick();

        rst = 0; tick(); rst = 1; tick();
        start_frame(3'b010, 16'h0000, 0, 0);
        frame_bits("d0000", {14'b0, 16'h0000, 2'b01}, 18, 18);
        tick();
        check("d0000 crc", crc, 5'h01);
        start_frame(3'b011, 0, 0, 0);
        frame_bits("crcf", 32'b1_1000_0001, 9, 9);
        check("crcf reload", crc, 5'h1F);
        tick();

        sp = 2;
        start_frame(3'b001, 0, 0, 2'b01);
        frame_bits("pre01", 32'b01, 2, 2);
        start_frame(3'b010, 16'hFFFF, 0, 0);
        frame_bits("dffff", {14'b0, 16'hFFFF, 2'b01}, 18, 18);
        tick();
        check("b2b busy", busy, 0);

        sp = 1;
        start_frame(3'b100, 0, 5'd7, 0);
        frame_bits("zero7", 0, 7, 7);
        tick();
        start_frame(3'b101, 16'hABCD, 5'd3, 0);
        frame_bits("raw3", 32'b101, 3, 3);
        tick();
        sp = 0;
        start_frame(3'b100, 0, 5'd0, 0);
        check("zero0 done", done, 1);
        check("zero0 ser", ser, 1);
        tick();
        check("zero0 done off", done, 0);
        check("zero0 busy", busy, 0);

        sp = 3;
        start_frame(3'b001, 0, 0, 2'b10);
        frame_bits("pre10", 32'b10, 2, 2);
        tick();
        check("pre10 busy", busy, 0);
        check("pre10 hold", ser, 0);

        sp = 1;
        start_frame(3'b010, 16'hA5A5, 0, 0);
        frame_bits("da5", {14'b0, 16'hA5A5, 2'b01}, 18, 5);
        en = 0;
        tick();
        check("en ser", ser, 1);
        check("en busy", busy, 0);
        check("en done", done, 0);
        check("en parity", parity, 2'b01);
        mode = 3'b001; start = 1;
        tick();
        check("en start ignored", busy, 0);
        en = 1;
        tick();

        start_frame(3'b110, 0, 0, 0);
        check("resv err", err, 1);
        check("resv busy", busy, 0);
        tick();
        check("resv err off", err, 0);

        start_frame(3'b010, 16'h8000, 0, 0);
        frame_bits("d8k", {14'b0, 16'h8000, 2'b11}, 18, 5);
        rst = 0;
        tick();
        check("mid rst ser", ser, 1);
        check("mid rst busy", busy, 0);
        check("mid rst parity", parity, 0);
        check("mid rst crc", crc, 5'h1F);
        rst = 1;
        tick();
        start_frame(3'b010, 16'h0000, 0, 0);
        frame_bits("d0b", {14'b0, 16'h0000, 2'b01}, 18, 18);
        tick();
        check("pre clr crc", crc, 5'h01);
        crc_clear = 1;
        tick();
        check("clr crc", crc, 5'h1F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ddr_tx_serializer.md
Name: ddr_tx_serializer

Overview:
Parametrised HDR-DDR transmit serializer, successor to the fixed-mode tx block. Sits between the DDR/CCC controller FSM and the SDA handler. Shifts preambles, data words, zero fills, raw fields and CRC words MSB-first, one bit per SCL edge (pos or neg). Generates word parity itself and accumulates CRC-5 internally while data words are sent.

Parameters:
DATA_W, 16, data word width in bits; must be even and at least 2.
LEN_W, 5, width of i_tx_len; must satisfy 2**LEN_W > DATA_W.
CRC_INIT, 5'h1F, CRC-5 seed value.
CRC_POLY, 5'h05, CRC-5 polynomial taps (x^5+x^2+1).

Ports:
i_sys_clk  in  1  system clock; single clock domain.
i_sys_rst  in  1  synchronous, active-low reset.
i_ddrccc_tx_en  in  1  block enable; low aborts any frame.
i_sclgen_scl_pos_edge  in  1  one-cycle strobe marking an SCL rising edge.
i_sclgen_scl_neg_edge  in  1  one-cycle strobe marking an SCL falling edge.
i_ddrccc_tx_start  in  1  frame request; sampled when idle or when o_ddrccc_mode_done is high.
i_ddrccc_tx_mode  in  3  frame type; sampled with start.
i_tx_data  in  DATA_W  payload; sampled with start.
i_tx_len  in  LEN_W  bit count for ZEROS and RAW modes.
i_preamble  in  2  preamble bits; sampled with start.
i_crc_clear  in  1  reload the CRC register with CRC_INIT.
o_sdahnd_serial_data  out  1  serial bit to the SDA handler.
o_ddrccc_mode_done  out  1  one-cycle pulse: last bit of the frame driven.
o_busy  out  1  frame in progress.
o_mode_err  out  1  one-cycle pulse: start received with a reserved mode.
o_crc_value  out  5  current CRC register.
o_parity  out  2  {P1,P0} of the last data word.

Behaviour:
- Reset (i_sys_rst low at a clock edge) drives these values:
  - o_sdahnd_serial_data = 1.
  - o_ddrccc_mode_done, o_busy, o_mode_err = 0.
  - o_parity = 0.
  - CRC register = CRC_INIT.
  - Shift register and counter cleared; state IDLE.
- Reset mid-frame discards the frame immediately.
- Mode encodings:
  - 3'b001 PREAMBLE: 2 bits, i_preamble[1] sent first.
  - 3'b010 DATA: DATA_W bits of i_tx_data, then P1, then P0.
    - P1 = XOR of odd-index bits.
    - P0 = XOR of even-index bits, XOR 1.
  - 3'b011 CRC: token 4'b1100, then the 5-bit CRC, MSB first; 9 bits total.
  - 3'b100 ZEROS: i_tx_len zero bits.
  - 3'b101 RAW: the low i_tx_len bits of i_tx_data, MSB first. i_tx_len > DATA_W is clamped to DATA_W.
  - 3'b000, 3'b110, 3'b111 are reserved.
- Start accepted on a reserved mode: pulse o_mode_err, remain IDLE, no bits sent.
- FSM states:
  - IDLE: a start is accepted here.
  - LOAD: frame latched into a (DATA_W+2)-bit shift register; bit count set.
  - SHIFT: on each edge strobe, drive the next bit and decrement the count.
  - DONE: the bit count reached 0.
- Edge handling:
  - Pos and neg strobes in the same cycle count as one edge.
  - The first bit is driven on the first strobe strictly after the start cycle.
- o_ddrccc_mode_done:
  - Registered; asserted in the same cycle the last bit appears on o_sdahnd_serial_data.
  - A start sampled in that cycle is accepted back-to-back; its first bit goes out on the next strobe with no idle edge.
  - With no new start, go to IDLE and deassert o_busy the following cycle.
- Zero-length ZEROS or RAW frame: o_ddrccc_mode_done pulses one cycle after start, no bits are sent, and the output is unchanged.
- Between frames o_sdahnd_serial_data holds the last driven bit.
- CRC update, DATA frames only, payload bits only (parity excluded):
  - For each payload bit b: fb = crc[4]^b; crc = {crc[3:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - Updated in the same cycle the bit is driven.
- CRC frame:
  - Sends the CRC value latched at start.
  - Reloads CRC_INIT in the cycle o_ddrccc_mode_done pulses.
- i_crc_clear:
  - Takes effect next cycle and has priority over an update in that cycle.
  - Ignored while a CRC frame is shifting.
- o_parity updates at start of a DATA frame.
- i_ddrccc_tx_en low (IDLE or mid-frame):
  - Next cycle: o_sdahnd_serial_data = 1, o_busy = 0, no done pulse, state IDLE.
  - CRC register and o_parity are retained.
  - Starts are ignored while tx_en is low.
- A start while busy, other than in the done cycle, is ignored.

Test Plan:
- DATA 16'h8000, continuous strobes -> 1 followed by fifteen 0s, then P1=1, P0=1 (18 bits); done pulses with the 18th bit; o_parity = 2'b11.
- DATA 16'h0001 -> parity bits 0,0; DATA 16'h0000 from reset, then CRC frame -> 1,1,0,0,0,0,0,0,1 (token, then CRC 5'h01); afterwards o_crc_value = 5'h1F.
- PREAMBLE 2'b01 followed back-to-back by DATA 16'hFFFF -> 0,1, then sixteen 1s, then 0,1; no gap edge; two done pulses.
- ZEROS len 7, then RAW len 3 with data 3'b101, then ZEROS len 0 -> seven 0s; then 1,0,1; then a done pulse one cycle after start with no edge consumed.
- Pos and neg strobes together on every edge during a PREAMBLE frame -> exactly 2 bits; tx_en dropped after bit 5 of a DATA frame -> output 1 and o_busy 0 next cycle, no done; reserved mode 3'b110 -> o_mode_err pulse, o_busy stays 0.
- Reset asserted mid-DATA -> all outputs at reset values next cycle; i_crc_clear after a DATA frame -> o_crc_value = 5'h1F next cycle.
